speaker_i2s_tx: RTL and testbench



---
 rtl/audio_pkg.sv | 31 +++
 rtl/audio_clk_gen.sv | 52 +++++
 rtl/speaker_i2s_tx.sv | 82 ++++++++
 tb/tb_speaker_i2s_tx.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants and types for the I2S speaker path: sample width, frame slot
// count, default clock divider ratios and the slot-to-bit mapping of a frame.
package audio_pkg;

  localparam int SAMPLE_W          = 16;
  localparam int SLOTS_PER_FRAME   = 32;
  localparam int SLOT_W            = $clog2(SLOTS_PER_FRAME);
  localparam int MCLK_DIV_LOG2_DEF = 2;
  localparam int SCK_DIV_LOG2_DEF  = 2;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_t;

  // Bit carried in a given slot: slot 0 is the previous right LSB, 1..16 the
  // left word MSB-first, 17..31 the right word bits 15..1.
  function automatic logic slot_bit(input stereo_t pair, input logic r0,
                                    input logic [SLOT_W-1:0] slot);
    logic [3:0] idx;
    idx = 4'(5'd16 - slot);
    if (slot == 5'd0) begin
      slot_bit = r0;
    end else if (slot <= 5'd16) begin
      slot_bit = pair.left[idx];
    end else begin
      slot_bit = pair.right[idx];
    end
  endfunction

endpackage

// File: rtl/audio_clk_gen.sv
// Free-running frame counter producing the DAC clocks straight from counter
// bits, the current slot index and registered slot-end / frame-end strobes.
module audio_clk_gen
  import audio_pkg::*;
#(
  parameter int MCLK_DIV_LOG2 = MCLK_DIV_LOG2_DEF,
  parameter int SCK_DIV_LOG2  = SCK_DIV_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              o_mclk,
  output logic              o_sck,
  output logic              o_lrck,
  output logic [SLOT_W-1:0] o_slot,
  output logic              o_slot_end,
  output logic              o_frame_end
);

  localparam int CW = MCLK_DIV_LOG2 + SCK_DIV_LOG2 + 5;
  localparam int SW = CW - SLOT_W;

  logic [CW-1:0] r_cnt;
  logic          r_slot_end;
  logic          r_frame_end;
  logic [CW-1:0] w_cnt_next;

  always_comb begin
    w_cnt_next = r_cnt + CW'(1);
  end

  // Strobes are registered from the next count so they are high during the
  // last clk of a slot / frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_slot_end  <= 1'b0;
      r_frame_end <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_next;
      r_slot_end  <= &w_cnt_next[SW-1:0];
      r_frame_end <= &w_cnt_next;
    end
  end

  assign o_mclk      = r_cnt[MCLK_DIV_LOG2-1];
  assign o_sck       = r_cnt[MCLK_DIV_LOG2+SCK_DIV_LOG2-1];
  assign o_lrck      = r_cnt[CW-1];
  assign o_slot      = r_cnt[CW-1 -: SLOT_W];
  assign o_slot_end  = r_slot_end;
  assign o_frame_end = r_frame_end;

endmodule

// File: rtl/speaker_i2s_tx.sv
// I2S transmitter for the CS4344 DAC: latches one stereo pair per frame and
// shifts it out MSB-first with the one-bit I2S delay on audio_sdin.
module speaker_i2s_tx
  import audio_pkg::*;
#(
  parameter int MCLK_DIV_LOG2 = MCLK_DIV_LOG2_DEF,
  parameter int SCK_DIV_LOG2  = SCK_DIV_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] audio_left,
  input  logic [SAMPLE_W-1:0] audio_right,
  output logic                audio_mclk,
  output logic                audio_lrck,
  output logic                audio_sck,
  output logic                audio_sdin,
  output logic                sample_req
);

  logic [SLOT_W-1:0] w_slot;
  logic [SLOT_W-1:0] w_next_slot;
  logic              w_slot_end;
  logic              w_frame_end;
  logic              w_prev_r0_next;
  logic              w_sdin_next;

  stereo_t r_lat;
  logic    r_prev_r0;
  logic    r_sdin;

  audio_clk_gen #(
    .MCLK_DIV_LOG2(MCLK_DIV_LOG2),
    .SCK_DIV_LOG2 (SCK_DIV_LOG2)
  ) u_clk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .o_mclk     (audio_mclk),
    .o_sck      (audio_sck),
    .o_lrck     (audio_lrck),
    .o_slot     (w_slot),
    .o_slot_end (w_slot_end),
    .o_frame_end(w_frame_end)
  );

  // sdin is loaded one clk ahead for the upcoming slot; slot 0 must see the
  // old right LSB that is being moved into prev_r0 in the same cycle.
  always_comb begin
    w_next_slot    = w_slot + 5'd1;
    w_prev_r0_next = r_prev_r0;
    if (w_frame_end) begin
      w_prev_r0_next = r_lat.right[0];
    end else begin
      w_prev_r0_next = r_prev_r0;
    end
    w_sdin_next = slot_bit(r_lat, w_prev_r0_next, w_next_slot);
  end

  // Sample latches and serial data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat     <= '0;
      r_prev_r0 <= 1'b0;
      r_sdin    <= 1'b0;
    end else begin
      r_prev_r0 <= w_prev_r0_next;
      if (w_frame_end) begin
        r_lat <= '{left: audio_left, right: audio_right};
      end else begin
        r_lat <= r_lat;
      end
      if (w_slot_end) begin
        r_sdin <= w_sdin_next;
      end else begin
        r_sdin <= r_sdin;
      end
    end
  end

  assign audio_sdin = r_sdin;
  assign sample_req = w_frame_end;

endmodule

// File: tb/tb_speaker_i2s_tx.sv
// Scoreboard bench for speaker_i2s_tx: stimulus pushes the pair present at each
// capture; a monitor deserialises sdin on SCK rising edges and compares.
module tb_speaker_i2s_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] audio_left = 16'h0000;
  logic [15:0] audio_right = 16'h0000;
  logic        audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_req;

  speaker_i2s_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .audio_left (audio_left),
    .audio_right(audio_right),
    .audio_mclk (audio_mclk),
    .audio_lrck (audio_lrck),
    .audio_sck  (audio_sck),
    .audio_sdin (audio_sdin),
    .sample_req (sample_req)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [8:0]  m_cnt = 9'd0;
  logic [15:0] mon_l = 16'h0000;
  logic [15:0] mon_r = 16'h0000;
  bit          has_partial = 1'b0;
  int          mode = 0;
  int          tog = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t cnt=%0d: got %h expected %h", name, $time, m_cnt, got, exp);
    end
  endtask

  // Monitor: frame position is tracked from clock edges since reset release.
  always @(posedge clk) begin
    int          slot;
    logic [31:0] expw;
    #1;
    if (!rst_n) begin
      m_cnt       = 9'd0;
      has_partial = 1'b0;
      chk("reset_outputs", {27'd0, audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_req}, 32'd0);
    end else begin
      m_cnt = m_cnt + 9'd1;
      chk("clocks_req", {28'd0, audio_mclk, audio_sck, audio_lrck, sample_req},
          {28'd0, m_cnt[1], m_cnt[3], m_cnt[8], (m_cnt == 9'd511)});
      if (m_cnt[3:0] == 4'd8) begin
        slot = int'(m_cnt[8:4]);
        if (slot == 0) begin
          if (has_partial) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL word_queue: got empty queue expected pending pair");
            end else begin
              expw = exp_q.pop_front();
              chk("word", {mon_l, mon_r[15:1], audio_sdin}, expw);
            end
            has_partial = 1'b0;
          end else begin
            chk("slot0_after_reset", {31'd0, audio_sdin}, 32'd0);
          end
        end else if (slot <= 16) begin
          mon_l[16-slot] = audio_sdin;
        end else begin
          mon_r[32-slot] = audio_sdin;
          if (slot == 31) has_partial = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    case (mode)
      1: begin
        tog++;
        if (tog == 37) begin
          tog = 0;
          audio_left = (audio_left == 16'h1234) ? 16'hFFFF : 16'h1234;
        end
      end
      2: begin
        if ($urandom_range(0, 63) == 0) begin
          audio_left  = 16'($urandom);
          audio_right = 16'($urandom);
        end
      end
      default: ;
    endcase
    if (rst_n && m_cnt == 9'd511) exp_q.push_back({audio_left, audio_right});
  endtask

  task automatic run(input int n, input int md);
    mode = md;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int guard;
    exp_q.push_back(32'd0);
    repeat (10) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    audio_left  = 16'hA5F0;
    audio_right = 16'h0F0F;
    run(3 * 512, 0);

    audio_right = 16'h0001;
    run(512, 0);
    audio_right = 16'h0000;
    run(1024, 0);

    audio_left = 16'h1234;
    tog = 0;
    run(1536, 1);

    run(2048, 2);

    mode  = 0;
    guard = 0;
    do begin
      step();
      guard++;
    end while (m_cnt != 9'd300 && guard < 600);
    if (m_cnt != 9'd300) begin
      checks++;
      errors++;
      $display("FAIL find_cnt300: got cnt %0d expected 300", m_cnt);
    end
    rst_n = 1'b0;
    #1;
    chk("async_reset", {27'd0, audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_req}, 32'd0);
    exp_q.delete();
    exp_q.push_back(32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    audio_left  = 16'($urandom);
    audio_right = 16'($urandom);
    run(3 * 512, 2);
    run(1024, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
